// File: rtl/vga_pkg.sv
// Shared 1024x768@60 raster timing constants and the raster bus type
// consumed by every stage of the video pipeline.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int HOR_BLANK_START = 1024;
    localparam int HOR_SYNC_START  = 1048;
    localparam int HOR_SYNC_END    = 1183;
    localparam int HOR_TOTAL       = 1344;

    localparam int VER_BLANK_START = 768;
    localparam int VER_SYNC_START  = 771;
    localparam int VER_SYNC_END    = 776;
    localparam int VER_TOTAL       = 806;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } raster_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running raster timing generator; every output is a flop and the
// flags are decoded from the next position so they never skew the counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int FRAME_CNT_W  = 8,
    parameter int H_TOTAL      = HOR_TOTAL,
    parameter int H_BLANK      = HOR_BLANK_START,
    parameter int H_SYNC_START = HOR_SYNC_START,
    parameter int H_SYNC_END   = HOR_SYNC_END,
    parameter int V_TOTAL      = VER_TOTAL,
    parameter int V_BLANK      = VER_BLANK_START,
    parameter int V_SYNC_START = VER_SYNC_START,
    parameter int V_SYNC_END   = VER_SYNC_END
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic [CNT_W-1:0]       hcount,
    output logic [CNT_W-1:0]       vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblnk,
    output logic                   vblnk,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLK  = CNT_W'(H_BLANK);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_BLK  = CNT_W'(V_BLANK);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC_END);

    raster_t                raster_q, raster_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        raster_d      = raster_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (raster_q.hcount == H_LAST) begin
            raster_d.hcount = '0;
            if (raster_q.vcount == V_LAST) begin
                raster_d.vcount = '0;
                frame_start_d   = 1'b1;
                frame_cnt_d     = frame_cnt_q + FRAME_CNT_W'(1);
            end else begin
                raster_d.vcount = raster_q.vcount + CNT_W'(1);
            end
        end else begin
            raster_d.hcount = raster_q.hcount + CNT_W'(1);
        end
        // Decode from the next position so flags line up with counters.
        raster_d.hblnk = (raster_d.hcount >= H_BLK);
        raster_d.vblnk = (raster_d.vcount >= V_BLK);
        raster_d.hsync = (raster_d.hcount >= H_SS) &&
                         (raster_d.hcount <= H_SE);
        raster_d.vsync = (raster_d.vcount >= V_SS) &&
                         (raster_d.vcount <= V_SE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raster_q      <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (en) begin
            raster_q      <= raster_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hcount      = raster_q.hcount;
    assign vcount      = raster_q.vcount;
    assign hsync       = raster_q.hsync;
    assign vsync       = raster_q.vsync;
    assign hblnk       = raster_q.hblnk;
    assign vblnk       = raster_q.vblnk;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing, a shrunk
// instance so whole frames and the frame counter wrap fit in a short run.
module tb_vga_timing;
    import vga_pkg::*;

    localparam int BHT = 1344, BHB = 1024, BHSS = 1048, BHSE = 1183;
    localparam int BVT = 806,  BVB = 768,  BVSS = 771,  BVSE = 776;
    localparam int SHT = 12, SHB = 8, SHSS = 9, SHSE = 10;
    localparam int SVT = 8,  SVB = 5, SVSS = 6, SVSE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_nb, en_b, rst_ns, en_s;
    logic [CNT_W-1:0] hc_b, vc_b, hc_s, vc_s;
    logic hs_b, vs_b, hbl_b, vbl_b, fs_b;
    logic hs_s, vs_s, hbl_s, vbl_s, fs_s;
    logic [7:0] fc_b, fc_s;

    vga_timing #(.FRAME_CNT_W(8)) u_big (
        .clk(clk), .rst_n(rst_nb), .en(en_b),
        .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
        .hblnk(hbl_b), .vblnk(vbl_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing #(
        .FRAME_CNT_W(8),
        .H_TOTAL(SHT), .H_BLANK(SHB), .H_SYNC_START(SHSS), .H_SYNC_END(SHSE),
        .V_TOTAL(SVT), .V_BLANK(SVB), .V_SYNC_START(SVSS), .V_SYNC_END(SVSE)
    ) u_small (
        .clk(clk), .rst_n(rst_ns), .en(en_s),
        .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
        .hblnk(hbl_s), .vblnk(vbl_s), .frame_start(fs_s), .frame_cnt(fc_s)
    );

    int cmp = 0;
    int fails = 0;

    // Reference model: linear pixel index within the frame, completed
    // frame count, and whether the last enabled step wrapped the frame.
    int  pb = 0, fb = 0;
    bit  sb = 0;
    int  ps = 0, fsm = 0;
    bit  ss = 0;

    wire [34:0] obs_b = {hc_b, vc_b, hs_b, vs_b, hbl_b, vbl_b, fs_b, fc_b};
    wire [34:0] obs_s = {hc_s, vc_s, hs_s, vs_s, hbl_s, vbl_s, fs_s, fc_s};

    function automatic logic [34:0] expect_vec(
        int p, int f, bit fs, int ht,
        int hb, int hss, int hse, int vb, int vss, int vse);
        int h, v;
        logic a, b, c, d;
        h = p % ht;
        v = p / ht;
        a = (h >= hss) && (h <= hse);
        b = (v >= vss) && (v <= vse);
        c = (h >= hb);
        d = (v >= vb);
        return {CNT_W'(h), CNT_W'(v), a, b, c, d, fs, 8'(f)};
    endfunction

    function automatic logic [34:0] exp_b();
        return expect_vec(pb, fb, sb, BHT, BHB, BHSS, BHSE, BVB, BVSS, BVSE);
    endfunction

    function automatic logic [34:0] exp_s();
        return expect_vec(ps, fsm, ss, SHT, SHB, SHSS, SHSE, SVB, SVSS, SVSE);
    endfunction

    task automatic step_b();
        pb = (pb + 1) % (BHT * BVT);
        sb = (pb == 0);
        if (sb) fb = fb + 1;
    endtask

    task automatic step_s();
        ps = (ps + 1) % (SHT * SVT);
        ss = (ps == 0);
        if (ss) fsm = fsm + 1;
    endtask

    task automatic test_reset();
        rst_nb = 1'b0; rst_ns = 1'b0;
        en_b = 1'b1; en_s = 1'b1;
        repeat (3) @(negedge clk);
        cmp++;
        if (obs_b !== 35'd0) begin
            fails++;
            $display("FAIL reset_big: got %h want 0", obs_b);
        end
        cmp++;
        if (obs_s !== 35'd0) begin
            fails++;
            $display("FAIL reset_small: got %h want 0", obs_s);
        end
        en_s = 1'b0;
        rst_nb = 1'b1; rst_ns = 1'b1;
    endtask

    task automatic test_line();
        int hs_cnt, hb_cnt;
        hs_cnt = 0; hb_cnt = 0;
        for (int i = 0; i < 2 * BHT + 5; i++) begin
            en_b = 1'b1;
            @(posedge clk);
            step_b();
            @(negedge clk);
            cmp++;
            if (obs_b !== exp_b()) begin
                fails++;
                $display("FAIL line cyc %0d: got %h want %h", i, obs_b, exp_b());
            end
            if (vc_b == 11'd0) begin
                hs_cnt += int'(hs_b);
                hb_cnt += int'(hbl_b);
            end
        end
        cmp++;
        if (hs_cnt != 136) begin
            fails++;
            $display("FAIL hsync_width: got %0d want 136", hs_cnt);
        end
        // Line 0 lacks pixel 0 (shown only in reset), blank count unaffected.
        cmp++;
        if (hb_cnt != 320) begin
            fails++;
            $display("FAIL hblnk_width: got %0d want 320", hb_cnt);
        end
    endtask

    task automatic test_pause();
        int guard;
        logic [34:0] held;
        guard = 0;
        while (pb != 3 * BHT + 1047 && guard < 8000) begin
            en_b = 1'b1;
            @(posedge clk);
            step_b();
            @(negedge clk);
            guard++;
            cmp++;
            if (obs_b !== exp_b()) begin
                fails++;
                $display("FAIL pause_run: got %h want %h", obs_b, exp_b());
            end
        end
        cmp++;
        if (hc_b !== 11'd1047) begin
            fails++;
            $display("FAIL pause_reach: got h=%0d want 1047", hc_b);
        end
        held = obs_b;
        en_b = 1'b0;
        repeat (10) begin
            @(negedge clk);
            cmp++;
            if (obs_b !== exp_b()) begin
                fails++;
                $display("FAIL pause_hold: got %h want %h", obs_b, exp_b());
            end
        end
        en_b = 1'b1;
        @(posedge clk);
        step_b();
        @(negedge clk);
        cmp++;
        if (hc_b !== 11'd1048 || hs_b !== 1'b1 || vc_b !== held[23:13]) begin
            fails++;
            $display("FAIL pause_resume: got h=%0d hs=%b want h=1048 hs=1",
                     hc_b, hs_b);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (pb != 4 * BHT + 500 && guard < 4000) begin
            en_b = 1'b1;
            @(posedge clk);
            step_b();
            @(negedge clk);
            guard++;
            cmp++;
            if (obs_b !== exp_b()) begin
                fails++;
                $display("FAIL areset_run: got %h want %h", obs_b, exp_b());
            end
        end
        #2 rst_nb = 1'b0;
        #1;
        pb = 0; fb = 0; sb = 0;
        cmp++;
        if (obs_b !== 35'd0) begin
            fails++;
            $display("FAIL areset_async: got %h want 0", obs_b);
        end
        @(negedge clk);
        rst_nb = 1'b1;
        for (int i = 0; i < 50; i++) begin
            en_b = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (en_b) step_b();
            @(negedge clk);
            cmp++;
            if (obs_b !== exp_b()) begin
                fails++;
                $display("FAIL areset_after: got %h want %h", obs_b, exp_b());
            end
        end
    endtask

    task automatic test_frames_small();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3 * SHT * SVT; i++) begin
            en_s = 1'b1;
            @(posedge clk);
            step_s();
            @(negedge clk);
            pulses += int'(fs_s);
            cmp++;
            if (obs_s !== exp_s()) begin
                fails++;
                $display("FAIL frame3 cyc %0d: got %h want %h", i, obs_s, exp_s());
            end
        end
        cmp++;
        if (pulses != 3 || fc_s !== 8'd3) begin
            fails++;
            $display("FAIL frame3_count: got %0d/%0d want 3/3", pulses, fc_s);
        end
    endtask

    task automatic test_wrap_small();
        int pulses;
        bit saw_zero;
        pulses = 0; saw_zero = 0;
        for (int i = 0; i < 256 * SHT * SVT; i++) begin
            en_s = 1'b1;
            @(posedge clk);
            step_s();
            @(negedge clk);
            pulses += int'(fs_s);
            if (fs_s && fc_s == 8'd0) saw_zero = 1;
            cmp++;
            if (obs_s !== exp_s()) begin
                fails++;
                $display("FAIL wrap cyc %0d: got %h want %h", i, obs_s, exp_s());
            end
        end
        cmp++;
        if (pulses != 256 || !saw_zero || fc_s !== 8'd3) begin
            fails++;
            $display("FAIL wrap_count: got %0d pulses fc=%0d want 256 fc=3",
                     pulses, fc_s);
        end
    endtask

    task automatic test_pause_on_strobe();
        int guard;
        guard = 0;
        en_s = 1'b1;
        while (!ss && guard < 200) begin
            @(posedge clk);
            step_s();
            @(negedge clk);
            guard++;
        end
        cmp++;
        if (fs_s !== 1'b1) begin
            fails++;
            $display("FAIL strobe_reach: got %b want 1", fs_s);
        end
        en_s = 1'b0;
        repeat (5) begin
            @(negedge clk);
            cmp++;
            if (obs_s !== exp_s()) begin
                fails++;
                $display("FAIL strobe_hold: got %h want %h", obs_s, exp_s());
            end
        end
        en_s = 1'b1;
        @(posedge clk);
        step_s();
        @(negedge clk);
        cmp++;
        if (fs_s !== 1'b0 || obs_s !== exp_s()) begin
            fails++;
            $display("FAIL strobe_resume: got %h want %h", obs_s, exp_s());
        end
    endtask

    task automatic test_random_en_small();
        for (int i = 0; i < 2000; i++) begin
            en_s = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (en_s) step_s();
            @(negedge clk);
            cmp++;
            if (obs_s !== exp_s()) begin
                fails++;
                $display("FAIL rand_en cyc %0d: got %h want %h", i, obs_s, exp_s());
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pause();
        test_async_reset();
        test_frames_small();
        test_wrap_small();
        test_pause_on_strobe();
        test_random_en_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
